// File: rtl/fp_pkg.sv
// Shared FP writeback definitions: field widths, fflags bit positions,
// the queued slow-result entry layout and the writeback source select.
package fp_pkg;

    localparam int unsigned FFLAGS_W  = 5;
    localparam int unsigned NV        = 4;
    localparam int unsigned DZ        = 3;
    localparam int unsigned OF        = 2;
    localparam int unsigned UF        = 1;
    localparam int unsigned NX        = 0;
    localparam int unsigned FP_REG_AW = 5;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic                 kill;
        logic [FP_REG_AW-1:0] rd;
        logic [XLEN-1:0]      data;
        logic [FFLAGS_W-1:0]  flags;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_FAST,
        SEL_FIFO,
        SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/fp_wb_fifo.sv
// Slow-result queue for the FP writeback arbiter. Each entry carries a kill
// bit that can be set in place when a younger fast write targets the same rd.
module fp_wb_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  wb_entry_t            push_entry,
    input  logic                 pop,
    input  logic [DEPTH-1:0]     kill_set,
    input  logic [FP_REG_AW-1:0] match_rd,
    output wb_entry_t            head,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH-1:0]     rd_match
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_comb begin
        rd_match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_match[i] = (mem[i].rd == match_rd);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i].kill <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_set[i]) begin
                    mem[i].kill <= 1'b1;
                end
            end
            // A push overrides any kill marking on the (unoccupied) slot it fills.
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: merges the fast pipe and the queued
// div/sqrt results, resolves WAW kills, requests bubbles, and accumulates fflags.
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fast_valid,
    input  logic [FP_REG_AW-1:0] fast_rd,
    input  logic [XLEN-1:0]      fast_data,
    input  logic [FFLAGS_W-1:0]  fast_flags,
    input  logic                 slow_valid,
    output logic                 slow_ready,
    input  logic [FP_REG_AW-1:0] slow_rd,
    input  logic [XLEN-1:0]      slow_data,
    input  logic [FFLAGS_W-1:0]  slow_flags,
    output logic                 stall_req,
    output logic                 fp_reg_write,
    output logic [FP_REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [FFLAGS_W-1:0]  fflags_acc,
    input  logic                 fflags_clr
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic                 full;
    logic                 empty;
    logic                 xfer;
    logic                 push;
    logic                 pop;
    logic [DEPTH-1:0]     rd_match;
    logic [DEPTH-1:0]     kill_set;
    wb_entry_t            head;
    wb_entry_t            push_entry;
    wb_sel_e              sel;
    logic                 ret_write;
    logic [FP_REG_AW-1:0] ret_rd;
    logic [XLEN-1:0]      ret_data;
    logic [FFLAGS_W-1:0]  ret_flags;
    logic [CW-1:0]        starve_cnt;
    logic                 starving;

    assign slow_ready = reset && !full;
    assign xfer       = slow_valid && slow_ready;

    always_comb begin
        sel = SEL_NONE;
        if (fast_valid) begin
            sel = SEL_FAST;
        end else if (!empty) begin
            sel = SEL_FIFO;
        end else if (xfer) begin
            sel = SEL_BYPASS;
        end
    end

    always_comb begin
        ret_write = 1'b0;
        ret_rd    = fast_rd;
        ret_data  = fast_data;
        ret_flags = fast_flags;
        case (sel)
            SEL_FAST: begin
                ret_write = 1'b1;
            end
            SEL_FIFO: begin
                ret_write = !head.kill;
                ret_rd    = head.rd;
                ret_data  = head.data;
                ret_flags = head.flags;
            end
            SEL_BYPASS: begin
                ret_write = 1'b1;
                ret_rd    = slow_rd;
                ret_data  = slow_data;
                ret_flags = slow_flags;
            end
            default: ;
        endcase
    end

    assign pop      = (sel == SEL_FIFO);
    assign push     = xfer && (sel != SEL_BYPASS);
    assign kill_set = fast_valid ? rd_match : '0;
    assign starving = fast_valid && !empty;

    // A slow result arriving alongside a fast write to the same rd is older, so it is killed on entry.
    assign push_entry = '{
        kill:  fast_valid && (slow_rd == fast_rd),
        rd:    slow_rd,
        data:  slow_data,
        flags: slow_flags
    };

    fp_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_set   (kill_set),
        .match_rd   (fast_rd),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .rd_match   (rd_match)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            fp_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            fflags_acc   <= '0;
            stall_req    <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            fp_reg_write <= ret_write;
            if (sel != SEL_NONE) begin
                wb_rd   <= ret_rd;
                wb_data <= ret_data;
            end
            if (fflags_clr) begin
                fflags_acc <= (sel != SEL_NONE) ? ret_flags : '0;
            end else if (sel != SEL_NONE) begin
                fflags_acc <= fflags_acc | ret_flags;
            end
            // Any cycle without a starving head (pop or empty) drops the request immediately.
            stall_req <= starving && (starve_cnt >= CW'(STARVE_LIMIT - 1));
            if (starving) begin
                if (starve_cnt < CW'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model of the writeback rules.
module tb_fp_wb_arbiter;

    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fast_valid = 1'b0;
    logic [4:0]  fast_rd = '0;
    logic [31:0] fast_data = '0;
    logic [4:0]  fast_flags = '0;
    logic        slow_valid = 1'b0;
    logic        slow_ready;
    logic [4:0]  slow_rd = '0;
    logic [31:0] slow_data = '0;
    logic [4:0]  slow_flags = '0;
    logic        stall_req;
    logic        fp_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  fflags_acc;
    logic        fflags_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          kill;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } ent_t;

    ent_t        q[$];
    int unsigned m_wait  = 0;
    logic        m_we    = 1'b0;
    logic        m_stall = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_data  = '0;
    logic [4:0]  m_acc   = '0;

    fp_wb_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .fast_valid(fast_valid), .fast_rd(fast_rd), .fast_data(fast_data), .fast_flags(fast_flags),
        .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_rd(slow_rd), .slow_data(slow_data),
        .slow_flags(slow_flags), .stall_req(stall_req), .fp_reg_write(fp_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    always #5 clock = ~clock;

    // Reference model: one call per rising edge, using the inputs present at that edge.
    task automatic model_step();
        bit          sel = 0;
        bit          we  = 0;
        bit          ready;
        bit          xfer;
        bit          nonempty;
        logic [4:0]  r_rd = '0;
        logic [31:0] r_data = '0;
        logic [4:0]  r_flags = '0;
        ent_t        e;
        if (!reset) begin
            q.delete();
            m_wait = 0; m_we = 0; m_stall = 0; m_rd = '0; m_data = '0; m_acc = '0;
        end else begin
            ready    = (q.size() < DEPTH);
            xfer     = slow_valid && ready;
            nonempty = (q.size() != 0);
            if (fast_valid) begin
                sel = 1; we = 1; r_rd = fast_rd; r_data = fast_data; r_flags = fast_flags;
                foreach (q[i]) if (q[i].rd == fast_rd) q[i].kill = 1;
                if (xfer) q.push_back('{kill: (slow_rd == fast_rd), rd: slow_rd, data: slow_data, flags: slow_flags});
            end else if (nonempty) begin
                e = q.pop_front();
                sel = 1; we = !e.kill; r_rd = e.rd; r_data = e.data; r_flags = e.flags;
                if (xfer) q.push_back('{kill: 0, rd: slow_rd, data: slow_data, flags: slow_flags});
            end else if (xfer) begin
                sel = 1; we = 1; r_rd = slow_rd; r_data = slow_data; r_flags = slow_flags;
            end
            m_stall = fast_valid && nonempty && (m_wait >= STARVE_LIMIT - 1);
            m_wait  = (fast_valid && nonempty) ? m_wait + 1 : 0;
            m_we    = we;
            if (sel) begin
                m_rd = r_rd; m_data = r_data;
            end
            if (fflags_clr) m_acc = sel ? r_flags : 5'h00;
            else if (sel)   m_acc = m_acc | r_flags;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'hDEADBEEF;
        repeat (3) tick();
        checks++; if (slow_ready !== 1'b0) begin errors++; $display("FAIL reset_slow_ready: got %b expected 0", slow_ready); end
        checks++; if (fp_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", fp_reg_write); end
        checks++; if (fflags_acc !== 5'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", fflags_acc); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb: got rd=%0d data=%h expected 0/0", wb_rd, wb_data); end
        reset = 1'b1; slow_valid = 1'b0;
        #1;
        checks++; if (slow_ready !== 1'b1) begin errors++; $display("FAIL release_slow_ready: got %b expected 1", slow_ready); end
    endtask

    task automatic test_slow_only();
        slow_valid = 1'b1; slow_rd = 5'd3; slow_data = 32'h3F800000; slow_flags = 5'h01;
        tick();
        slow_valid = 1'b0;
        checks++; if (fp_reg_write !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h3F800000)
            begin errors++; $display("FAIL slow_bypass: got we=%b rd=%0d data=%h expected 1/3/3f800000", fp_reg_write, wb_rd, wb_data); end
        checks++; if (fflags_acc !== 5'h01) begin errors++; $display("FAIL slow_flags: got %h expected 01", fflags_acc); end
        tick();
        checks++; if (fp_reg_write !== 1'b0) begin errors++; $display("FAIL slow_one_cycle: got we=%b expected 0", fp_reg_write); end
    endtask

    task automatic test_fast_slow_same();
        fast_valid = 1'b1; fast_rd = 5'd1; fast_data = 32'h11111111; fast_flags = 5'h00;
        slow_valid = 1'b1; slow_rd = 5'd2; slow_data = 32'h22222222; slow_flags = 5'h00;
        tick();
        fast_valid = 1'b0; slow_valid = 1'b0;
        checks++; if (fp_reg_write !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h11111111)
            begin errors++; $display("FAIL order_first: got we=%b rd=%0d data=%h expected 1/1/11111111", fp_reg_write, wb_rd, wb_data); end
        tick();
        checks++; if (fp_reg_write !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h22222222)
            begin errors++; $display("FAIL order_second: got we=%b rd=%0d data=%h expected 1/2/22222222", fp_reg_write, wb_rd, wb_data); end
    endtask

    task automatic test_starvation();
        fast_valid = 1'b1; fast_rd = 5'd10; fast_data = 32'hF0F0F0F0; fast_flags = 5'h00;
        slow_valid = 1'b1; slow_rd = 5'd11; slow_data = 32'hAAAA0011; slow_flags = 5'h00;
        tick();
        for (int k = 1; k <= STARVE_LIMIT; k++) begin
            slow_valid = (k == 1); slow_rd = 5'd12; slow_data = 32'hAAAA0012;
            tick();
            if (k == 1) begin
                slow_valid = 1'b0;
                checks++; if (slow_ready !== 1'b0) begin errors++; $display("FAIL fifo_full: got slow_ready=%b expected 0", slow_ready); end
            end
            checks++; if (stall_req !== (k == STARVE_LIMIT) || stall_req !== m_stall)
                begin errors++; $display("FAIL starve_%0d: got stall=%b expected %b", k, stall_req, (k == STARVE_LIMIT)); end
        end
        tick();
        checks++; if (stall_req !== 1'b1 || fp_reg_write !== 1'b1 || wb_rd !== 5'd10)
            begin errors++; $display("FAIL stall_violation: got stall=%b we=%b rd=%0d expected 1/1/10", stall_req, fp_reg_write, wb_rd); end
        fast_valid = 1'b0;
        tick();
        checks++; if (stall_req !== 1'b0 || fp_reg_write !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 32'hAAAA0011)
            begin errors++; $display("FAIL starve_pop1: got stall=%b we=%b rd=%0d data=%h expected 0/1/11/aaaa0011", stall_req, fp_reg_write, wb_rd, wb_data); end
        tick();
        checks++; if (fp_reg_write !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'hAAAA0012)
            begin errors++; $display("FAIL starve_pop2: got we=%b rd=%0d data=%h expected 1/12/aaaa0012", fp_reg_write, wb_rd, wb_data); end
    endtask

    task automatic test_waw_kill();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        fast_valid = 1'b1; fast_rd = 5'd7; fast_data = 32'h00000077; fast_flags = 5'h00;
        slow_valid = 1'b1; slow_rd = 5'd5; slow_data = 32'hAAAA0000; slow_flags = 5'h02;
        tick();
        slow_valid = 1'b0; fast_rd = 5'd5; fast_data = 32'h12345678;
        tick();
        fast_valid = 1'b0;
        checks++; if (fp_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h12345678 || fflags_acc !== 5'h00)
            begin errors++; $display("FAIL waw_fast: got we=%b rd=%0d data=%h acc=%h expected 1/5/12345678/00", fp_reg_write, wb_rd, wb_data, fflags_acc); end
        tick();
        checks++; if (fp_reg_write !== 1'b0 || fflags_acc !== 5'h02)
            begin errors++; $display("FAIL waw_killed_pop: got we=%b acc=%h expected 0/02", fp_reg_write, fflags_acc); end
        tick();
        checks++; if (fp_reg_write !== 1'b0 || slow_ready !== 1'b1)
            begin errors++; $display("FAIL waw_drained: got we=%b ready=%b expected 0/1", fp_reg_write, slow_ready); end
    endtask

    task automatic test_fflags_clr();
        fast_valid = 1'b1; fast_rd = 5'd4; fast_data = 32'h40400000; fast_flags = 5'h1F;
        tick();
        checks++; if (fflags_acc !== 5'h1F) begin errors++; $display("FAIL acc_set: got %h expected 1f", fflags_acc); end
        fast_flags = 5'h04; fflags_clr = 1'b1;
        tick();
        checks++; if (fflags_acc !== 5'h04) begin errors++; $display("FAIL clr_with_retire: got %h expected 04", fflags_acc); end
        fast_valid = 1'b0;
        tick();
        fflags_clr = 1'b0;
        checks++; if (fflags_acc !== 5'h00) begin errors++; $display("FAIL clr_idle: got %h expected 00", fflags_acc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 79) != 0);
            fast_valid = m_stall ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1) == 1;
            fast_rd    = 5'($urandom_range(0, 7));
            fast_data  = $urandom;
            fast_flags = 5'($urandom);
            slow_valid = ($urandom_range(0, 2) != 0);
            slow_rd    = 5'($urandom_range(0, 7));
            slow_data  = $urandom;
            slow_flags = 5'($urandom);
            fflags_clr = ($urandom_range(0, 15) == 0);
            #1;
            checks++; if (slow_ready !== (reset && q.size() < DEPTH))
                begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, slow_ready, (reset && q.size() < DEPTH)); end
            tick();
            checks++; if (fp_reg_write !== m_we || stall_req !== m_stall || fflags_acc !== m_acc)
                begin errors++; $display("FAIL rnd_ctrl[%0d]: got we=%b stall=%b acc=%h expected %b/%b/%h", n, fp_reg_write, stall_req, fflags_acc, m_we, m_stall, m_acc); end
            if (m_we) begin
                checks++; if (wb_rd !== m_rd || wb_data !== m_data)
                    begin errors++; $display("FAIL rnd_wb[%0d]: got rd=%0d data=%h expected %0d/%h", n, wb_rd, wb_data, m_rd, m_data); end
            end
        end
        reset = 1'b1; fast_valid = 1'b0; slow_valid = 1'b0; fflags_clr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_slow_only();
        test_fast_slow_same();
        test_starvation();
        test_waw_kill();
        test_fflags_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
Writeback arbiter directly upstream of the FP register file write port. It merges results from the single-cycle FP pipe (fast) and the multi-cycle FP div/sqrt unit (slow) into one registered write (fp_reg_write/wb_rd/wb_data) per cycle. Slow results are held in a small FIFO, and a starvation counter requests a fast-pipe bubble when needed. It also resolves write-after-write ordering and accumulates sticky FP exception flags.

Parameters:
DEPTH, 2, slow-result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req asserts

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
fast_valid  in  1  fast pipe result valid this cycle (cannot be back-pressured)
fast_rd  in  5  fast destination register
fast_data  in  32  fast result
fast_flags  in  5  fast fflags {NV,DZ,OF,UF,NX}
slow_valid  in  1  slow unit result valid
slow_ready  out  1  FIFO can accept; transfer = slow_valid & slow_ready
slow_rd  in  5  slow destination register
slow_data  in  32  slow result
slow_flags  in  5  slow fflags
stall_req  out  1  registered request that the fast pipe issue no result next cycle
fp_reg_write  out  1  registered write enable to the register file
wb_rd  out  5  registered write address
wb_data  out  32  registered write data
fflags_acc  out  5  sticky OR of the flags of all retired results
fflags_clr  in  1  clears fflags_acc (CSR write)

Behaviour:
- Reset (reset=0 at posedge): FIFO emptied, kill bits cleared, starve counter=0. stall_req=0, fp_reg_write=0, wb_rd=0, wb_data=0, fflags_acc=0. slow_ready=0 while reset=0.
- Reset mid-operation discards all queued slow results. No write is issued for them.
- slow_ready = !full. It is combinational from state only, never from slow_valid.
- Latency: the result selected in cycle N appears on wb_* in cycle N+1, with fp_reg_write=1 for exactly one cycle. The register file samples on the following negedge.
- Priority each cycle:
  - fast_valid=1: fast is selected.
  - Else if the FIFO is non-empty: the head is popped and selected.
  - Else if there is a slow transfer: the slow result bypasses the FIFO and is selected directly (still one-cycle latency).
  - Else: fp_reg_write=0 next cycle; wb_rd/wb_data hold their previous value.
- A slow transfer pushes into the FIFO unless it is bypassed. Push and pop in the same cycle are legal when full: the push succeeds only if slow_ready was 1, and slow_ready does not look ahead at a pop.
- Write-after-write kill: when fast is selected with fast_rd = rd of any FIFO entry (or of a same-cycle slow push), that entry's kill bit is set.
  - A killed entry still pops in order and its flags still accumulate.
  - A killed entry produces fp_reg_write=0.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and fast_valid=1; resets to 0 on any pop or when the FIFO is empty.
  - When count >= STARVE_LIMIT-1, stall_req=1 next cycle. stall_req clears the cycle after the pop.
  - If fast_valid=1 while stall_req=1 (protocol violation), fast still wins and no data is lost.
- fflags_acc: on each retirement (selected result, killed or not), flags are ORed in the same edge as the wb_* update.
  - fflags_clr=1 clears fflags_acc.
  - If fflags_clr coincides with a retirement, the result is the new flags only (clear, then OR).
- FIFO pointers use log2(DEPTH)+1 bits with wrap-around; full/empty are derived from the MSB compare.

Decomposition:
- Shared package fp_pkg holds: FFLAGS_W=5; flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0; FP_REG_AW=5; XLEN=32.
- One sub-module, fp_wb_fifo: DEPTH-entry synchronous FIFO of {kill, rd, data, flags}. It provides a per-entry rd compare output used to set kill bits.

Test Plan:
1. Reset held low 3 cycles with slow_valid=1 -> slow_ready=0, fp_reg_write=0, fflags_acc=0. After release, slow_ready=1.
2. Slow only: slow_rd=3, data=0x3F800000, flags=0x01, FIFO empty -> next cycle fp_reg_write=1, wb_rd=3, wb_data=0x3F800000, fflags_acc=0x01.
3. Fast and slow same cycle (fast_rd=1, slow_rd=2) -> cycle+1 writes rd=1; cycle+2 writes rd=2; order preserved.
4. Fill FIFO (2 slow pushes under continuous fast_valid) -> slow_ready=0. With fast_valid held high, stall_req=1 after STARVE_LIMIT cycles. Drop fast_valid -> head pops, stall_req returns to 0.
5. Queue slow rd=5 data=0xAAAA0000, then fast rd=5 data=0x12345678 -> fast write occurs. Slow entry later pops with fp_reg_write=0, and its flags are still ORed into fflags_acc.
6. fflags_acc=0x1F; fflags_clr=1 with a retiring fast_flags=0x04 -> fflags_acc=0x04.
